// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32 core (LW, SW, R-type, BEQ), plus retired-instruction counter.
// Latency with memory always ready: LW 5 cycles, SW 4, R-type 4, BEQ 3; outputs decode the current state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their memory request stable until mem_ready, with no timeout.
module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       aluop,
   output logic             halted,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_HALT     = 4'd9
   } state_t;

   state_t state_q;

   assign state = state_q;

   // State sequencing and retire counting; a retiring transition bumps the counter in the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         retired <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) state_q <= S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                  OP_RTYPE:     state_q <= S_EXEC_R;
                  OP_BRANCH:    state_q <= S_BRANCH;
                  default:      state_q <= S_HALT;
               endcase
            end
            S_MEM_ADDR: begin
               // Opcode is re-examined here; anything that is no longer a load/store stops the core.
               if (opcode == OP_LW)      state_q <= S_MEM_RD;
               else if (opcode == OP_SW) state_q <= S_MEM_WR;
               else                      state_q <= S_HALT;
            end
            S_MEM_RD: begin
               if (mem_ready) state_q <= S_MEM_WB;
            end
            S_MEM_WB: begin
               state_q <= S_FETCH;
               retired <= retired + CNT_W'(1);
            end
            S_MEM_WR: begin
               if (mem_ready) begin
                  state_q <= S_FETCH;
                  retired <= retired + CNT_W'(1);
               end
            end
            S_EXEC_R: begin
               state_q <= S_R_WB;
            end
            S_R_WB: begin
               state_q <= S_FETCH;
               retired <= retired + CNT_W'(1);
            end
            S_BRANCH: begin
               state_q <= S_FETCH;
               retired <= retired + CNT_W'(1);
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               // Unused encodings recover to FETCH without retiring anything.
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   // Moore decode of the datapath controls; only FETCH and BRANCH look at mem_ready/zero.
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      aluop      = 2'b00;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            aluop     = 2'b10;
         end
         S_R_WB: begin
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vector table plus hand-written halt, reset and wrap sequences.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units later.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;

   logic        pc_write, pc_src, ir_write, mem_read, mem_write, iord;
   logic        reg_write, mem_to_reg, alu_src_a, halted;
   logic [1:0]  alu_src_b, aluop;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        w_pc_write, w_pc_src, w_ir_write, w_mem_read, w_mem_write, w_iord;
   logic        w_reg_write, w_mem_to_reg, w_alu_src_a, w_halted;
   logic [1:0]  w_alu_src_b, w_aluop;
   logic [3:0]  w_state;
   logic [3:0]  w_retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .halted(halted),
      .state(state), .retired(retired)
   );

   multicycle_control_fsm #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write), .mem_read(w_mem_read),
      .mem_write(w_mem_write), .iord(w_iord), .reg_write(w_reg_write), .mem_to_reg(w_mem_to_reg),
      .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .aluop(w_aluop), .halted(w_halted),
      .state(w_state), .retired(w_retired)
   );

   // {pc_write,pc_src,ir_write,mem_read,mem_write,iord,reg_write,mem_to_reg,alu_src_a,alu_src_b,aluop,halted}
   logic [13:0] act_ctl;
   assign act_ctl = {pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                     reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, halted};

   localparam logic [13:0] F1  = 14'b1_0_1_1_0_0_0_0_0_01_00_0;
   localparam logic [13:0] F0  = 14'b0_0_0_1_0_0_0_0_0_01_00_0;
   localparam logic [13:0] DEC = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [13:0] MA  = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [13:0] MRD = 14'b0_0_0_1_0_1_0_0_0_00_00_0;
   localparam logic [13:0] MWB = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
   localparam logic [13:0] MWR = 14'b0_0_0_0_1_1_0_0_0_00_00_0;
   localparam logic [13:0] EXR = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [13:0] RWB = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
   localparam logic [13:0] BRT = 14'b1_1_0_0_0_0_0_0_1_00_01_0;
   localparam logic [13:0] BRN = 14'b0_1_0_0_0_0_0_0_1_00_01_0;

   localparam logic [6:0] LW  = 7'h03;
   localparam logic [6:0] SW  = 7'h23;
   localparam logic [6:0] RT  = 7'h33;
   localparam logic [6:0] BEQ = 7'h63;
   localparam logic [6:0] BAD = 7'h7F;

   typedef struct {
      logic        rst_n;
      logic [6:0]  op;
      logic        z;
      logic        mr;
      logic [3:0]  st;
      logic [13:0] ctl;
      logic [31:0] ret;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic r, logic [6:0] op, logic z, logic mr,
                              logic [3:0] st, logic [13:0] ctl, logic [31:0] ret);
      vec_t x;
      x.rst_n = r; x.op = op; x.z = z; x.mr = mr; x.st = st; x.ctl = ctl; x.ret = ret;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b0;

      // Reset held for two cycles
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_retired", retired, 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_mem_read", 32'(mem_read), 32'd1);
      chk("release_iord", 32'(iord), 32'd0);

      // R-type
      tbl.push_back(v(1, RT,  0, 1, 4'd0, F1,  0));
      tbl.push_back(v(1, RT,  0, 1, 4'd1, DEC, 0));
      tbl.push_back(v(1, RT,  0, 1, 4'd6, EXR, 0));
      tbl.push_back(v(1, RT,  0, 1, 4'd7, RWB, 0));
      // LW with three stall cycles in MEM_RD
      tbl.push_back(v(1, LW,  0, 1, 4'd0, F1,  1));
      tbl.push_back(v(1, LW,  0, 1, 4'd1, DEC, 1));
      tbl.push_back(v(1, LW,  0, 1, 4'd2, MA,  1));
      tbl.push_back(v(1, LW,  0, 0, 4'd3, MRD, 1));
      tbl.push_back(v(1, LW,  0, 0, 4'd3, MRD, 1));
      tbl.push_back(v(1, LW,  0, 0, 4'd3, MRD, 1));
      tbl.push_back(v(1, LW,  0, 1, 4'd3, MRD, 1));
      tbl.push_back(v(1, LW,  0, 1, 4'd4, MWB, 1));
      // SW with a fetch stall and a write stall
      tbl.push_back(v(1, SW,  0, 0, 4'd0, F0,  2));
      tbl.push_back(v(1, SW,  0, 1, 4'd0, F1,  2));
      tbl.push_back(v(1, SW,  0, 1, 4'd1, DEC, 2));
      tbl.push_back(v(1, SW,  0, 1, 4'd2, MA,  2));
      tbl.push_back(v(1, SW,  0, 0, 4'd5, MWR, 2));
      tbl.push_back(v(1, SW,  0, 1, 4'd5, MWR, 2));
      // BEQ taken, then not taken
      tbl.push_back(v(1, BEQ, 1, 1, 4'd0, F1,  3));
      tbl.push_back(v(1, BEQ, 1, 1, 4'd1, DEC, 3));
      tbl.push_back(v(1, BEQ, 1, 1, 4'd8, BRT, 3));
      tbl.push_back(v(1, BEQ, 0, 1, 4'd0, F1,  4));
      tbl.push_back(v(1, BEQ, 0, 1, 4'd1, DEC, 4));
      tbl.push_back(v(1, BEQ, 0, 1, 4'd8, BRN, 4));
      // Illegal opcode
      tbl.push_back(v(1, BAD, 0, 1, 4'd0, F1,  5));
      tbl.push_back(v(1, BAD, 0, 1, 4'd1, DEC, 5));

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n; opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].mr;
         #2;
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("vec%0d_ctl", i), 32'(act_ctl), 32'(tbl[i].ctl));
         chk($sformatf("vec%0d_retired", i), retired, tbl[i].ret);
         tick();
      end

      // HALT is absorbing; counter frozen
      for (int i = 0; i < 20; i++) begin
         opcode = RT; mem_ready = 1'(i & 1); zero = 1'(i >> 1);
         #2;
         chk($sformatf("halt%0d_state", i), 32'(state), 32'd9);
         chk($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
         chk($sformatf("halt%0d_mem_read", i), 32'(mem_read), 32'd0);
         chk($sformatf("halt%0d_retired", i), retired, 32'd5);
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("halt_recover_state", 32'(state), 32'd0);
      chk("halt_recover_halted", 32'(halted), 32'd0);
      chk("halt_recover_retired", retired, 32'd0);

      // Reset during a stalled store
      opcode = RT; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      opcode = SW;
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1'b0;
      #1;
      chk("wr_stall_state", 32'(state), 32'd5);
      chk("wr_stall_mem_write", 32'(mem_write), 32'd1);
      chk("wr_stall_retired", retired, 32'd1);
      rst_n = 1'b0;
      tick();
      #1;
      chk("wr_reset_mem_write", 32'(mem_write), 32'd0);
      chk("wr_reset_state", 32'(state), 32'd0);
      chk("wr_reset_retired", retired, 32'd0);
      rst_n = 1'b1;

      // Counter wrap on the 4-bit instance
      opcode = RT; mem_ready = 1'b1;
      for (int i = 0; i < 15 * 4; i++) tick();
      #1;
      chk("wrap15_retired4", 32'(w_retired), 32'd15);
      chk("wrap15_retired32", retired, 32'd15);
      for (int i = 0; i < 4; i++) tick();
      #1;
      chk("wrap16_retired4", 32'(w_retired), 32'd0);
      chk("wrap16_retired32", retired, 32'd16);
      chk("wrap16_state4", 32'(w_state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
